// File: rtl/approx_eval_pkg.sv
// Shared widths, FSM state encoding and saturating arithmetic for the
// approximate-adder error monitor.
package approx_eval_pkg;

  localparam int N_DEF     = 16;
  localparam int CNT_W_DEF = 32;
  localparam int ACC_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Adds b to a and clamps at the all-ones value of a w-bit field (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      sat_add = lim[63:0];
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of a W-bit vector.
module popcount_tree #(
  parameter int W = 17
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   cnt
);
  localparam int CW = $clog2(W + 1);

  // Sum of all set bits; synthesis balances the chain into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Two-stage checker: stage 1 measures error distance and bit flips of each
// approximate sum, stage 2 accumulates saturating run statistics.
module approx_adder_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int HAS_CO = 0,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic [N-1:0]     approx_s,
  input  logic             approx_co,
  output logic             busy,
  output logic             res_valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N:0]       max_ed,
  output logic [CNT_W-1:0] bitflip_cnt
);
  localparam int HD_W = $clog2(N + 2);

  state_t           state_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             res_valid_r;
  logic             s1_valid_r;
  logic [N:0]       s1_ed_r;
  logic [HD_W-1:0]  s1_hd_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [ACC_W-1:0] sum_ed_r;
  logic [N:0]       max_ed_r;
  logic [CNT_W-1:0] bitflip_cnt_r;

  logic [N:0]       exact_s;
  logic [N:0]       approx_full_s;
  logic [N:0]       ed_s;
  logic [HD_W-1:0]  hd_s;
  logic             accept_s;

  assign accept_s = in_valid && in_ready_r;

  // Exact reference sum and absolute error distance of the incoming sample.
  always_comb begin
    exact_s = {1'b0, x} + {1'b0, y};
    if (HAS_CO != 0) begin
      approx_full_s = {approx_co, approx_s};
    end else begin
      approx_full_s = {1'b0, approx_s};
    end
    if (exact_s >= approx_full_s) begin
      ed_s = exact_s - approx_full_s;
    end else begin
      ed_s = approx_full_s - exact_s;
    end
  end

  popcount_tree #(.W(N + 1)) u_popcount (
    .vec (exact_s ^ approx_full_s),
    .cnt (hd_s)
  );

  // Run-control FSM; start wins over finish and discards any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else if (start) begin
      state_r     <= RUN;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b1;
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
        RUN: begin
          if (finish) begin
            state_r    <= DRAIN;
            in_ready_r <= 1'b0;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_valid_r) begin
            state_r     <= REPORT;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b1;
          end else begin
            busy_r <= 1'b1;
          end
        end
        REPORT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 capture and stage 2 accumulation; start clears but still admits a coincident sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      s1_ed_r       <= '0;
      s1_hd_r       <= '0;
      sample_cnt_r  <= '0;
      err_cnt_r     <= '0;
      sum_ed_r      <= '0;
      max_ed_r      <= '0;
      bitflip_cnt_r <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_ed_r <= ed_s;
        s1_hd_r <= hd_s;
      end else begin
        s1_ed_r <= s1_ed_r;
        s1_hd_r <= s1_hd_r;
      end
      if (start) begin
        sample_cnt_r  <= '0;
        err_cnt_r     <= '0;
        sum_ed_r      <= '0;
        max_ed_r      <= '0;
        bitflip_cnt_r <= '0;
      end else if (s1_valid_r) begin
        sample_cnt_r  <= CNT_W'(sat_add(64'(sample_cnt_r), 64'd1, CNT_W));
        err_cnt_r     <= CNT_W'(sat_add(64'(err_cnt_r), 64'(s1_ed_r != '0), CNT_W));
        sum_ed_r      <= ACC_W'(sat_add(64'(sum_ed_r), 64'(s1_ed_r), ACC_W));
        bitflip_cnt_r <= CNT_W'(sat_add(64'(bitflip_cnt_r), 64'(s1_hd_r), CNT_W));
        if (s1_ed_r > max_ed_r) begin
          max_ed_r <= s1_ed_r;
        end else begin
          max_ed_r <= max_ed_r;
        end
      end else begin
        sample_cnt_r <= sample_cnt_r;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign res_valid   = res_valid_r;
  assign sample_cnt  = sample_cnt_r;
  assign err_cnt     = err_cnt_r;
  assign sum_ed      = sum_ed_r;
  assign max_ed      = max_ed_r;
  assign bitflip_cnt = bitflip_cnt_r;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Drives one sample stream into three monitor configurations (default, with
// carry-out, 4-bit counters) and compares each against a list-based model.
module tb_approx_adder_error_monitor;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid, approx_co;
  logic [15:0] x, y, approx_s;

  logic        rdy_a, busy_a, rv_a;
  logic [31:0] sc_a, ec_a, bf_a;
  logic [47:0] se_a;
  logic [16:0] me_a;

  logic        rdy_b, busy_b, rv_b;
  logic [31:0] sc_b, ec_b, bf_b;
  logic [47:0] se_b;
  logic [16:0] me_b;

  logic        rdy_c, busy_c, rv_c;
  logic [3:0]  sc_c, ec_c, bf_c;
  logic [47:0] se_c;
  logic [16:0] me_c;

  approx_adder_error_monitor dut_a (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(rdy_a), .x(x), .y(y), .approx_s(approx_s), .approx_co(approx_co),
    .busy(busy_a), .res_valid(rv_a), .sample_cnt(sc_a), .err_cnt(ec_a),
    .sum_ed(se_a), .max_ed(me_a), .bitflip_cnt(bf_a));

  approx_adder_error_monitor #(.HAS_CO(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(rdy_b), .x(x), .y(y), .approx_s(approx_s), .approx_co(approx_co),
    .busy(busy_b), .res_valid(rv_b), .sample_cnt(sc_b), .err_cnt(ec_b),
    .sum_ed(se_b), .max_ed(me_b), .bitflip_cnt(bf_b));

  approx_adder_error_monitor #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(rdy_c), .x(x), .y(y), .approx_s(approx_s), .approx_co(approx_co),
    .busy(busy_c), .res_valid(rv_c), .sample_cnt(sc_c), .err_cnt(ec_c),
    .sum_ed(se_c), .max_ed(me_c), .bitflip_cnt(bf_c));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] vx [64];
  logic [15:0] vy [64];
  logic [15:0] vs [64];
  logic        vc [64];
  int          nv;

  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX48 = 64'h0000_FFFF_FFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Statistics expected from the list of samples sent in this run.
  task automatic check_one(input string tag, input bit has_co, input longint cmax,
                           input longint sc, input longint ec, input longint se,
                           input longint me, input longint bf);
    longint n_s = 0, n_e = 0, t_ed = 0, m_ed = 0, t_hd = 0;
    for (int i = 0; i < nv; i++) begin
      longint ex, ap, ed;
      ex = longint'(vx[i]) + longint'(vy[i]);
      ap = longint'(vs[i]) + ((has_co && vc[i]) ? 64'd65536 : 64'd0);
      ed = (ex > ap) ? ex - ap : ap - ex;
      n_s++;
      if (ed != 0) n_e++;
      t_ed += ed;
      if (ed > m_ed) m_ed = ed;
      t_hd += $countones(ex ^ ap);
    end
    check({tag, "_samples"}, sc, (n_s > cmax) ? cmax : n_s);
    check({tag, "_errs"},    ec, (n_e > cmax) ? cmax : n_e);
    check({tag, "_sum_ed"},  se, (t_ed > MAX48) ? MAX48 : t_ed);
    check({tag, "_max_ed"},  me, m_ed);
    check({tag, "_flips"},   bf, (t_hd > cmax) ? cmax : t_hd);
  endtask

  task automatic check_all(input string tag);
    check_one({tag, "_a"}, 1'b0, MAX32, longint'(sc_a), longint'(ec_a), longint'(se_a), longint'(me_a), longint'(bf_a));
    check_one({tag, "_b"}, 1'b1, MAX32, longint'(sc_b), longint'(ec_b), longint'(se_b), longint'(me_b), longint'(bf_b));
    check_one({tag, "_c"}, 1'b0, 64'd15, longint'(sc_c), longint'(ec_c), longint'(se_c), longint'(me_c), longint'(bf_c));
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_ready"}, 64'(rdy_a), 64'd0);
  endtask

  task automatic stream(input bit with_finish, input bit lat_chk);
    for (int i = 0; i < nv; i++) begin
      in_valid  = 1'b1;
      x         = vx[i];
      y         = vy[i];
      approx_s  = vs[i];
      approx_co = vc[i];
      finish    = with_finish && (i == nv - 1);
      tick();
      if (lat_chk) check("latency", 64'(sc_a), 64'(i));
    end
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  // Expects exactly one res_valid pulse per monitor, no later than 4 cycles after finish.
  task automatic wait_report(input string tag);
    int na = 0, nb = 0, nc = 0, first = -1;
    for (int k = 0; k < 8; k++) begin
      if (rv_a) begin
        na++;
        if (first < 0) first = k;
      end
      nb += int'(rv_b);
      nc += int'(rv_c);
      tick();
    end
    check({tag, "_pulse_a"}, 64'(na), 64'd1);
    check({tag, "_pulse_b"}, 64'(nb), 64'd1);
    check({tag, "_pulse_c"}, 64'(nc), 64'd1);
    check({tag, "_pulse_lat"}, 64'(first >= 0 && first <= 3), 64'd1);
  endtask

  task automatic count_no_pulse(input string tag, input int cycles);
    int n = 0;
    for (int k = 0; k < cycles; k++) begin
      n += int'(rv_a) + int'(rv_b) + int'(rv_c);
      tick();
    end
    check({tag, "_no_pulse"}, 64'(n), 64'd0);
  endtask

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic co);
    vx[i] = a; vy[i] = b; vs[i] = s; vc[i] = co;
  endtask

  task automatic full_run(input string tag);
    pulse_start();
    stream(1'b1, 1'b1);
    wait_report(tag);
    check_all(tag);
  endtask

  initial begin
    logic [16:0] ex;
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    x = '0; y = '0; approx_s = '0; approx_co = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 64'(rdy_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_res_valid", 64'(rv_a), 64'd0);
    check("rst_samples", 64'(sc_a), 64'd0);
    check("rst_sum_ed", 64'(se_a), 64'd0);
    check("rst_max_ed", 64'(me_a), 64'd0);

    // Exact sample, finish coincident with it.
    nv = 1; set_vec(0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    pulse_start();
    check("run_ready", 64'(rdy_a), 64'd1);
    check("run_busy", 64'(busy_a), 64'd1);
    stream(1'b1, 1'b1);
    wait_report("exact");
    check_all("exact");

    // Low-bit error, then confirm statistics stay frozen in IDLE.
    nv = 1; set_vec(0, 16'h00FF, 16'h00FF, 16'h01F0, 1'b0);
    full_run("lowbit");
    in_valid = 1'b1; x = 16'h1234; y = 16'h4321; approx_s = 16'h0000;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_frozen", 64'(sc_a), 64'd1);
    check("idle_frozen_ed", 64'(se_a), 64'h0E);

    // Carry loss: an error without carry-out, exact when carry-out is compared.
    nv = 1; set_vec(0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
    full_run("carry");

    // Burst of five with in_valid held high.
    nv = 5;
    set_vec(0, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0);
    set_vec(1, 16'h8001, 16'h0101, 16'h8100, 1'b0);
    set_vec(2, 16'h1000, 16'h0234, 16'h1234, 1'b0);
    set_vec(3, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0);
    set_vec(4, 16'h7777, 16'h0001, 16'h7778, 1'b0);
    full_run("burst");

    // Randomised mix of exact, near and wild results.
    nv = 40;
    for (int i = 0; i < nv; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      ex = {1'b0, a} + {1'b0, b};
      case ($urandom_range(0, 3))
        0: set_vec(i, a, b, ex[15:0], ex[16]);
        1: set_vec(i, a, b, ex[15:0] ^ 16'($urandom & 32'h00FF), ex[16]);
        2: set_vec(i, a, b, 16'($urandom), 1'($urandom));
        default: set_vec(i, a, b, ex[15:0], 1'b0);
      endcase
    end
    full_run("random");

    // Saturation of the 4-bit counters.
    nv = 20;
    for (int i = 0; i < nv; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      set_vec(i, a, b, a + b + 16'd1, 1'b0);
    end
    full_run("sat");

    // start during DRAIN discards the run.
    nv = 1; set_vec(0, 16'h0100, 16'h0100, 16'h0000, 1'b0);
    pulse_start();
    stream(1'b1, 1'b0);
    check("drain_busy", 64'(busy_a), 64'd1);
    check("drain_ready", 64'(rdy_a), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    count_no_pulse("drain_start", 6);
    check("drain_restart_samples", 64'(sc_a), 64'd0);
    check("drain_restart_sum_ed", 64'(se_a), 64'd0);
    check("drain_restart_max_ed", 64'(me_a), 64'd0);
    check("drain_restart_busy", 64'(busy_a), 64'd1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    nv = 0;
    wait_report("empty");
    check_all("empty");

    // Reset in the middle of a run.
    nv = 3;
    set_vec(0, 16'h00F0, 16'h000F, 16'h0000, 1'b0);
    set_vec(1, 16'h1111, 16'h2222, 16'h3333, 1'b0);
    set_vec(2, 16'h4000, 16'h4000, 16'h0001, 1'b0);
    pulse_start();
    stream(1'b0, 1'b0);
    tick();
    check("pre_rst_samples", 64'(sc_a), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 64'(rdy_a), 64'd0);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_samples", 64'(sc_a), 64'd0);
    check("mid_rst_errs", 64'(ec_a), 64'd0);
    check("mid_rst_sum_ed", 64'(se_a), 64'd0);
    check("mid_rst_max_ed", 64'(me_a), 64'd0);
    check("mid_rst_flips", 64'(bf_a), 64'd0);
    count_no_pulse("mid_rst", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
